// File: rtl/Types.sv
// Shared types for the ray-direction datapath.
// Holds the direction/square bundle and the direction_length FSM.
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef Q_BITS
`define Q_BITS 16
`endif

package Types;

  localparam int DL_WIDTH   = `WIDTH;
  localparam int SQRT_ITERS = `WIDTH;

  typedef struct packed {
    logic signed [DL_WIDTH-1:0]   x;
    logic signed [DL_WIDTH-1:0]   y;
    logic signed [DL_WIDTH-1:0]   z;
    logic        [2*DL_WIDTH-1:0] sqr_x;
    logic        [2*DL_WIDTH-1:0] sqr_y;
    logic        [2*DL_WIDTH-1:0] sqr_z;
  } RayDirection_sqr;

  typedef enum logic [1:0] {
    IDLE,
    SQRT,
    DONE
  } dl_state_t;

endpackage

// File: rtl/direction_length_isqrt_step.sv
// One restoring square-root iteration.
// Consumes two radicand bits and yields one root bit.
module isqrt_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] root,
  input  logic [1:0]       pair,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] root_nxt,
  output logic             q
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic [WIDTH-1:0] diff;

  // Remainder never exceeds WIDTH bits except after the final step,
  // where it is discarded, so a WIDTH-bit subtraction suffices.
  always_comb begin
    shifted  = {rem, pair};
    trial    = {root, 2'b01};
    q        = (shifted >= trial);
    diff     = shifted[WIDTH-1:0] - trial[WIDTH-1:0];
    rem_nxt  = q ? diff : shifted[WIDTH-1:0];
    root_nxt = {root[WIDTH-2:0], q};
  end

endmodule

// File: rtl/direction_length.sv
// Vector magnitude of a ray direction via iterative square root.
// One root bit per cycle; result held until the consumer takes it.
module direction_length
  import Types::*;
#(
  parameter int WIDTH  = `WIDTH,
  parameter int Q_BITS = `Q_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  RayDirection_sqr   RDS_in,
  output logic              ready,
  output logic              valid,
  input  logic              out_ready,
  output RayDirection_sqr   RDS_out,
  output logic [WIDTH-1:0]  length,
  output logic              sat
);

  localparam int SW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

  if (Q_BITS < 0 || Q_BITS >= WIDTH) begin : g_bad_q
    $error("direction_length: Q_BITS out of range");
  end

  dl_state_t        state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [SW-1:0]    sum_q;
  logic [SW-1:0]    sum_in;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] root_q;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] root_nxt;
  logic             q;
  logic             accept;
  logic             last;

  assign sum_in = SW'(RDS_in.sqr_x)
                + SW'(RDS_in.sqr_y)
                + SW'(RDS_in.sqr_z);

  isqrt_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .root     (root_q),
    .pair     (sum_q[SW-1:SW-2]),
    .rem_nxt  (rem_nxt),
    .root_nxt (root_nxt),
    .q        (q)
  );

  always_comb begin
    state_nxt = state;
    ready     = (state == IDLE);
    valid     = (state == DONE);
    accept    = (state == IDLE) && start;
    last      = (state == SQRT) && (cnt == LAST);
    unique case (state)
      IDLE:    if (start)     state_nxt = SQRT;
      SQRT:    if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      sum_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      length  <= '0;
      sat     <= 1'b0;
      RDS_out <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        RDS_out <= RDS_in;
        sum_q   <= sum_in;
        rem_q   <= '0;
        root_q  <= '0;
        cnt     <= '0;
      end else if (state == SQRT) begin
        sum_q  <= sum_q << 2;
        rem_q  <= rem_nxt;
        root_q <= {root_q[WIDTH-2:0], q};
        cnt    <= cnt + 1'b1;
        // Root's top bit set means it exceeds the signed range.
        if (last) begin
          sat    <= root_nxt[WIDTH-1];
          length <= root_nxt[WIDTH-1] ? MAX_POS : root_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_direction_length.sv
// Directed bench for direction_length.
// Hand-computed magnitudes, stall, and reset-abort cases.
module tb_direction_length;
  import Types::*;

  localparam int W = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            out_ready;
  RayDirection_sqr rds_in;
  RayDirection_sqr rds_out;
  logic            ready;
  logic            valid;
  logic            sat;
  logic [W-1:0]    length;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  direction_length #(.WIDTH(W), .Q_BITS(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .RDS_in    (rds_in),
    .ready     (ready),
    .valid     (valid),
    .out_ready (out_ready),
    .RDS_out   (rds_out),
    .length    (length),
    .sat       (sat)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic RayDirection_sqr mk(input logic signed [31:0] x,
                                         input logic signed [31:0] y,
                                         input logic signed [31:0] z);
    RayDirection_sqr r;
    logic signed [63:0] xe, ye, ze;
    xe = x;
    ye = y;
    ze = z;
    r.x = x;
    r.y = y;
    r.z = z;
    r.sqr_x = xe * xe;
    r.sqr_y = ye * ye;
    r.sqr_z = ze * ze;
    return r;
  endfunction

  task automatic start_op(input string tag, input RayDirection_sqr r);
    @(negedge clk);
    rds_in = r;
    check({tag, "_ready_idle"}, ready, 1);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_ready_busy"}, ready, 0);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!valid && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic consume(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_valid_drop"}, valid, 0);
    check({tag, "_ready_back"}, ready, 1);
    out_ready = 1'b0;
  endtask

  task automatic run(input string tag,
                     input logic signed [31:0] x,
                     input logic signed [31:0] y,
                     input logic signed [31:0] z,
                     input logic [31:0] exp_len,
                     input logic exp_sat);
    int cyc;
    start_op(tag, mk(x, y, z));
    wait_valid(cyc);
    check({tag, "_latency"}, cyc, 32);
    check({tag, "_length"}, length, exp_len);
    check({tag, "_sat"}, sat, exp_sat);
    check({tag, "_rds_x"}, rds_out.x, x);
    consume(tag);
  endtask

  initial begin
    int cyc;
    int seen;
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    rds_in    = '0;
    #12;
    check("rst_ready", ready, 1);
    check("rst_valid", valid, 0);
    check("rst_length", length, 0);
    check("rst_sat", sat, 0);
    check("rst_rds", rds_out == '0, 1);
    @(negedge clk);
    rst = 1'b0;

    run("v345", 32'h30000, 32'h40000, 0, 32'h0005_0000, 0);
    run("v111", 32'h10000, 32'h10000, 32'h10000, 32'h0001_BB67, 0);
    run("v100", 32'h10000, 0, 0, 32'h0001_0000, 0);
    run("vneg", -32'sh30000, 32'h40000, 0, 32'h0005_0000, 0);
    run("vmax", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
        32'h7FFF_FFFF, 1);
    run("vzero", 0, 0, 0, 32'h0, 0);

    start_op("stall", mk(32'h30000, 32'h40000, 0));
    wait_valid(cyc);
    check("stall_latency", cyc, 32);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rds_in = mk(32'h10000, 32'h10000, 32'h10000);
      start  = i[0];
      @(posedge clk);
      #1;
      check("stall_valid", valid, 1);
      check("stall_ready", ready, 0);
      check("stall_length", length, 32'h0005_0000);
      check("stall_rds_x", rds_out.x, 32'h30000);
    end
    @(negedge clk);
    out_ready = 1'b1;
    start     = 1'b1;
    @(posedge clk);
    #1;
    check("stall_valid_drop", valid, 0);
    check("stall_start_ignored", ready, 1);
    @(negedge clk);
    start     = 1'b0;
    out_ready = 1'b0;
    check("stall_still_idle", ready, 1);

    start_op("abort", mk(32'h10000, 32'h10000, 32'h10000));
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_ready", ready, 1);
    check("abort_valid", valid, 0);
    check("abort_length", length, 0);
    check("abort_sat", sat, 0);
    check("abort_rds", rds_out == '0, 1);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (valid) seen = 1;
    end
    check("abort_no_valid", seen, 0);
    run("fresh", 32'h10000, 32'h10000, 32'h10000, 32'h0001_BB67, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
